// File: rtl/fm_bus_arb.sv
// Two-requester round-robin arbiter for the internal register bus, with a
// programmable timeout that completes a transaction when the slave hangs.
module fm_bus_arb #(
    parameter int          P_ADR_WIDTH  = 10,
    parameter int          P_BE_WIDTH   = 4,
    parameter int          P_DATA_WIDTH = 32,
    parameter int          P_TIMEOUT    = 256,
    parameter logic [31:0] P_TO_DATA    = 32'hDEAD_DEAD
) (
    input  logic                    clk_core,
    input  logic                    rst,
    input  logic                    i_req_m0,
    input  logic                    i_wr_m0,
    input  logic [P_ADR_WIDTH-1:0]  i_adrs_m0,
    input  logic [P_BE_WIDTH-1:0]   i_be_m0,
    input  logic [P_DATA_WIDTH-1:0] i_wd_m0,
    output logic                    o_ack_m0,
    output logic                    o_rstr_m0,
    output logic [P_DATA_WIDTH-1:0] o_rd_m0,
    input  logic                    i_req_m1,
    input  logic                    i_wr_m1,
    input  logic [P_ADR_WIDTH-1:0]  i_adrs_m1,
    input  logic [P_BE_WIDTH-1:0]   i_be_m1,
    input  logic [P_DATA_WIDTH-1:0] i_wd_m1,
    output logic                    o_ack_m1,
    output logic                    o_rstr_m1,
    output logic [P_DATA_WIDTH-1:0] o_rd_m1,
    output logic                    o_req,
    output logic                    o_wr,
    output logic [P_ADR_WIDTH-1:0]  o_adrs,
    output logic [P_BE_WIDTH-1:0]   o_be,
    output logic [P_DATA_WIDTH-1:0] o_wd,
    input  logic                    i_ack,
    input  logic                    i_rstr,
    input  logic [P_DATA_WIDTH-1:0] i_rd,
    input  logic                    i_clr_timeout,
    output logic                    o_timeout
);
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RDATA = 2'd2} state_t;

    localparam bit                      TO_EN    = (P_TIMEOUT != 0);
    localparam logic [15:0]             TO_LIMIT = TO_EN ? 16'(P_TIMEOUT - 1) : 16'd0;
    localparam logic [P_DATA_WIDTH-1:0] TO_DATA  = P_DATA_WIDTH'(P_TO_DATA);

    state_t                  state;
    logic                    gnt;
    logic                    r_last;
    logic [15:0]             cnt;
    logic                    to_hit;
    logic                    slave_done;
    logic                    to_fire;
    logic                    ack_sig;
    logic                    rstr_sig;
    logic [P_DATA_WIDTH-1:0] rd_sig;
    logic                    next_gnt;

    // '>=' so a read acked on the limit cycle still times out in RDATA next cycle.
    always_comb begin
        to_hit     = TO_EN && (state != IDLE) && (cnt >= TO_LIMIT);
        ack_sig    = 1'b0;
        rstr_sig   = 1'b0;
        rd_sig     = '0;
        slave_done = 1'b0;
        case (state)
            CMD: begin
                ack_sig = i_ack || to_hit;
                if (i_ack) begin
                    slave_done = 1'b1;
                    if (!o_wr && i_rstr) begin
                        rstr_sig = 1'b1;
                        rd_sig   = i_rd;
                    end
                end else if (to_hit && !o_wr) begin
                    rstr_sig = 1'b1;
                    rd_sig   = TO_DATA;
                end
            end
            RDATA: begin
                if (i_rstr) begin
                    slave_done = 1'b1;
                    rstr_sig   = 1'b1;
                    rd_sig     = i_rd;
                end else if (to_hit) begin
                    rstr_sig = 1'b1;
                    rd_sig   = TO_DATA;
                end
            end
            default: ;
        endcase
        to_fire = to_hit && !slave_done;
    end

    assign next_gnt  = (i_req_m0 && i_req_m1) ? ~r_last : i_req_m1;

    assign o_ack_m0  = ack_sig  && !gnt;
    assign o_ack_m1  = ack_sig  &&  gnt;
    assign o_rstr_m0 = rstr_sig && !gnt;
    assign o_rstr_m1 = rstr_sig &&  gnt;
    assign o_rd_m0   = o_rstr_m0 ? rd_sig : '0;
    assign o_rd_m1   = o_rstr_m1 ? rd_sig : '0;

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            r_last    <= 1'b1;
            cnt       <= '0;
            o_req     <= 1'b0;
            o_wr      <= 1'b0;
            o_adrs    <= '0;
            o_be      <= '0;
            o_wd      <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (i_clr_timeout) o_timeout <= 1'b0;
            if (to_fire)       o_timeout <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_req_m0 || i_req_m1) begin
                        gnt    <= next_gnt;
                        o_req  <= 1'b1;
                        o_wr   <= next_gnt ? i_wr_m1   : i_wr_m0;
                        o_adrs <= next_gnt ? i_adrs_m1 : i_adrs_m0;
                        o_be   <= next_gnt ? i_be_m1   : i_be_m0;
                        o_wd   <= next_gnt ? i_wd_m1   : i_wd_m0;
                        cnt    <= '0;
                        state  <= CMD;
                    end
                end
                CMD: begin
                    cnt <= cnt + 16'd1;
                    if (ack_sig) begin
                        o_req <= 1'b0;
                        if (o_wr || rstr_sig) begin
                            state  <= IDLE;
                            r_last <= gnt;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    cnt <= cnt + 16'd1;
                    if (rstr_sig) begin
                        state  <= IDLE;
                        r_last <= gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_bus_arb.sv
// Directed bench for fm_bus_arb: write, read, round-robin, timeout,
// ack on the timeout cycle and reset during RDATA.
module tb_fm_bus_arb;
    logic        clk_core = 1'b0;
    logic        rst;
    logic        i_req_m0, i_wr_m0, i_req_m1, i_wr_m1;
    logic [9:0]  i_adrs_m0, i_adrs_m1;
    logic [3:0]  i_be_m0, i_be_m1;
    logic [31:0] i_wd_m0, i_wd_m1;
    logic        o_ack_m0, o_rstr_m0, o_ack_m1, o_rstr_m1;
    logic [31:0] o_rd_m0, o_rd_m1;
    logic        o_req, o_wr;
    logic [9:0]  o_adrs;
    logic [3:0]  o_be;
    logic [31:0] o_wd;
    logic        i_ack, i_rstr, i_clr_timeout, o_timeout;
    logic [31:0] i_rd;

    int errors = 0;
    int checks = 0;

    fm_bus_arb #(.P_TIMEOUT(8)) dut (
        .clk_core(clk_core), .rst(rst),
        .i_req_m0(i_req_m0), .i_wr_m0(i_wr_m0), .i_adrs_m0(i_adrs_m0),
        .i_be_m0(i_be_m0), .i_wd_m0(i_wd_m0),
        .o_ack_m0(o_ack_m0), .o_rstr_m0(o_rstr_m0), .o_rd_m0(o_rd_m0),
        .i_req_m1(i_req_m1), .i_wr_m1(i_wr_m1), .i_adrs_m1(i_adrs_m1),
        .i_be_m1(i_be_m1), .i_wd_m1(i_wd_m1),
        .o_ack_m1(o_ack_m1), .o_rstr_m1(o_rstr_m1), .o_rd_m1(o_rd_m1),
        .o_req(o_req), .o_wr(o_wr), .o_adrs(o_adrs), .o_be(o_be), .o_wd(o_wd),
        .i_ack(i_ack), .i_rstr(i_rstr), .i_rd(i_rd),
        .i_clr_timeout(i_clr_timeout), .o_timeout(o_timeout)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req_m0 = 0; i_wr_m0 = 0; i_adrs_m0 = '0; i_be_m0 = '0; i_wd_m0 = '0;
        i_req_m1 = 0; i_wr_m1 = 0; i_adrs_m1 = '0; i_be_m1 = '0; i_wd_m1 = '0;
        i_ack = 0; i_rstr = 0; i_rd = '0; i_clr_timeout = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(o_req), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_adrs", 32'(o_adrs), 0);
        chk("rst_ack_m0", 32'(o_ack_m0), 0);

        // Single write from m0, acked in the third o_req cycle
        i_req_m0 = 1; i_wr_m0 = 1; i_adrs_m0 = 10'h010; i_be_m0 = 4'hF; i_wd_m0 = 32'h1234_5678;
        tick();
        chk("wr_req_c1", 32'(o_req), 1);
        chk("wr_adrs", 32'(o_adrs), 32'h010);
        chk("wr_be", 32'(o_be), 32'hF);
        chk("wr_wd", o_wd, 32'h1234_5678);
        chk("wr_wr", 32'(o_wr), 1);
        tick();
        chk("wr_req_c2", 32'(o_req), 1);
        chk("wr_noack_c2", 32'(o_ack_m0), 0);
        tick();
        i_ack = 1; #1;
        chk("wr_req_c3", 32'(o_req), 1);
        chk("wr_ack_m0", 32'(o_ack_m0), 1);
        chk("wr_ack_m1", 32'(o_ack_m1), 0);
        i_req_m0 = 0;
        tick();
        i_ack = 0; #1;
        chk("wr_req_drop", 32'(o_req), 0);
        chk("wr_ack_end", 32'(o_ack_m0), 0);
        tick();
        chk("wr_no_regrant", 32'(o_req), 0);

        // Read from m1: ack, then read strobe two cycles later
        i_req_m1 = 1; i_wr_m1 = 0; i_adrs_m1 = 10'h3A4; i_be_m1 = 4'h3;
        tick();
        chk("rd_req", 32'(o_req), 1);
        chk("rd_adrs", 32'(o_adrs), 32'h3A4);
        chk("rd_wr", 32'(o_wr), 0);
        i_ack = 1; #1;
        chk("rd_ack_m1", 32'(o_ack_m1), 1);
        chk("rd_ack_m0", 32'(o_ack_m0), 0);
        chk("rd_rstr_early", 32'(o_rstr_m1), 0);
        i_req_m1 = 0;
        tick();
        i_ack = 0; #1;
        chk("rd_req_drop", 32'(o_req), 0);
        chk("rd_rstr_wait", 32'(o_rstr_m1), 0);
        tick();
        i_rstr = 1; i_rd = 32'hCAFE_F00D; #1;
        chk("rd_rstr_m1", 32'(o_rstr_m1), 1);
        chk("rd_data_m1", o_rd_m1, 32'hCAFE_F00D);
        chk("rd_rstr_m0", 32'(o_rstr_m0), 0);
        chk("rd_data_m0", o_rd_m0, 0);
        tick();
        i_rstr = 0; i_rd = '0; #1;
        chk("rd_rstr_end", 32'(o_rstr_m1), 0);
        chk("rd_data_end", o_rd_m1, 0);

        // Round robin after reset: m0, m1, m0, m1
        rst = 1; tick(); rst = 0;
        i_req_m0 = 1; i_wr_m0 = 1; i_adrs_m0 = 10'h100;
        i_req_m1 = 1; i_wr_m1 = 1; i_adrs_m1 = 10'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_req_%0d", k), 32'(o_req), 1);
            chk($sformatf("rr_adrs_%0d", k), 32'(o_adrs), (k % 2 == 0) ? 32'h100 : 32'h200);
            i_ack = 1; #1;
            if (k % 2 == 0) begin
                chk($sformatf("rr_ack_%0d", k), {o_ack_m1, o_ack_m0}, 32'b01);
                i_req_m0 = 0;
            end else begin
                chk($sformatf("rr_ack_%0d", k), {o_ack_m1, o_ack_m0}, 32'b10);
                i_req_m1 = 0;
            end
            tick();
            i_ack = 0; #1;
            chk($sformatf("rr_gap_%0d", k), 32'(o_req), 0);
            i_req_m0 = 1; i_req_m1 = 1;
        end
        i_req_m0 = 0; i_req_m1 = 0;
        tick();

        // Read from m0 with a silent slave: timeout in the 8th o_req cycle
        i_req_m0 = 1; i_wr_m0 = 0; i_adrs_m0 = 10'h055;
        tick();
        chk("to_req_c1", 32'(o_req), 1);
        for (int i = 0; i < 6; i++) tick();
        chk("to_req_c7", 32'(o_req), 1);
        chk("to_noack_c7", 32'(o_ack_m0), 0);
        tick();
        chk("to_ack_c8", 32'(o_ack_m0), 1);
        chk("to_rstr_c8", 32'(o_rstr_m0), 1);
        chk("to_data_c8", o_rd_m0, 32'hDEAD_DEAD);
        chk("to_ack_m1", 32'(o_ack_m1), 0);
        i_req_m0 = 0;
        tick();
        chk("to_flag", 32'(o_timeout), 1);
        chk("to_req_drop", 32'(o_req), 0);
        i_rstr = 1; i_rd = 32'h5555_AAAA; #1;
        chk("to_stray_rstr", 32'(o_rstr_m0), 0);
        chk("to_stray_rd", o_rd_m0, 0);
        i_rstr = 0; i_rd = '0;
        i_clr_timeout = 1;
        tick();
        i_clr_timeout = 0; #1;
        chk("to_clr", 32'(o_timeout), 0);

        // Write from m1 acked on the exact timeout cycle: normal completion
        i_req_m1 = 1; i_wr_m1 = 1; i_adrs_m1 = 10'h0AA; i_wd_m1 = 32'h0BAD_BEEF;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("race_req_c8", 32'(o_req), 1);
        i_ack = 1; #1;
        chk("race_ack_m1", 32'(o_ack_m1), 1);
        chk("race_rstr_m1", 32'(o_rstr_m1), 0);
        i_req_m1 = 0;
        tick();
        i_ack = 0; #1;
        chk("race_no_flag", 32'(o_timeout), 0);
        chk("race_req_drop", 32'(o_req), 0);

        // Reset during RDATA, then a stray read strobe
        i_req_m0 = 1; i_wr_m0 = 0; i_adrs_m0 = 10'h3FF; i_be_m0 = 4'h5;
        tick();
        i_ack = 1; #1;
        chk("rr_abort_ack", 32'(o_ack_m0), 1);
        i_req_m0 = 0;
        tick();
        i_ack = 0;
        rst = 1;
        tick();
        rst = 0; #1;
        chk("abort_req", 32'(o_req), 0);
        chk("abort_adrs", 32'(o_adrs), 0);
        chk("abort_be", 32'(o_be), 0);
        i_rstr = 1; i_rd = 32'h1111_2222; #1;
        chk("abort_stray_rstr", 32'(o_rstr_m0), 0);
        chk("abort_stray_rd", o_rd_m0, 0);
        tick();
        i_rstr = 0; i_rd = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
